// File: rtl/qpmm_out_stage.sv
// Output stage for the QPMM Montgomery multiplier: credit-based issue control, latency-matched tag line, Z canonicalization, output FIFO.
// Optional range check on Z (flags Z >= 4P) is built when QPMM_OUT_RANGE_CHK_EN is defined.
module qpmm_out_stage #(
  parameter int         W          = 256,
  parameter logic [W-1:0] P        = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
  parameter int         QPMM_LAT   = 80,
  parameter int         TAG_W      = 8,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [TAG_W-1:0] iss_tag,
  output logic             iss_ok,
  input  logic [W-1:0]     z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf,
  output logic             range_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [W+1:0] P1 = {2'b00, P};
  localparam logic [W+1:0] P2 = P1 + P1;
  localparam logic [W+1:0] P3 = P2 + P1;

  logic [CW-1:0]    credit_q;
  logic             ovf_q;
  logic             iss_acc_s, pop_s;
  logic [QPMM_LAT-1:0] dl_valid_q;
  logic [TAG_W-1:0] dl_tag_q [QPMM_LAT];
  logic             dl_out_valid_s;
  logic             s1_valid_q;
  logic [W-1:0]     s1_z_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [W+1:0]     s1_d1_q, s1_d2_q, s1_d3_q;
  logic [W-1:0]     sel_s;
  logic             s2_valid_q;
  logic [W-1:0]     s2_data_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [W-1:0]     fifo_data_q [FIFO_DEPTH];
  logic [TAG_W-1:0] fifo_tag_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q;
  logic             unused_s;

  assign iss_ok         = (credit_q != {CW{1'b0}});
  assign iss_acc_s      = iss_valid & iss_ok;
  assign pop_s          = out_valid_q & out_ready;
  assign dl_out_valid_s = dl_valid_q[QPMM_LAT-1];
  assign out_valid      = out_valid_q;
  assign out_data       = fifo_data_q[rd_ptr_q];
  assign out_tag        = fifo_tag_q[rd_ptr_q];
  assign ovf            = ovf_q;
  assign unused_s       = ^{s1_d1_q[W], s1_d2_q[W], s1_d3_q[W]};

  // Credit counter and sticky overflow flag; an issue without credit is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CW'(FIFO_DEPTH);
      ovf_q    <= 1'b0;
    end else begin
      case ({iss_acc_s, pop_s})
        2'b10:   credit_q <= credit_q - CW'(1);
        2'b01:   credit_q <= credit_q + CW'(1);
        default: credit_q <= credit_q;
      endcase
      ovf_q <= ovf_q | (iss_valid & ~iss_ok);
    end
  end

  // Valid/tag delay line matched to the multiplier latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_valid_q <= {QPMM_LAT{1'b0}};
      for (int i = 0; i < QPMM_LAT; i++) dl_tag_q[i] <= {TAG_W{1'b0}};
    end else begin
      for (int i = QPMM_LAT - 1; i > 0; i--) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_tag_q[i]   <= dl_tag_q[i-1];
      end
      dl_valid_q[0] <= iss_acc_s;
      dl_tag_q[0]   <= iss_tag;
    end
  end

  // Stage 1: capture Z and its trial subtractions only on an aligned valid slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_z_q     <= {W{1'b0}};
      s1_tag_q   <= {TAG_W{1'b0}};
      s1_d1_q    <= {(W+2){1'b0}};
      s1_d2_q    <= {(W+2){1'b0}};
      s1_d3_q    <= {(W+2){1'b0}};
    end else begin
      s1_valid_q <= dl_out_valid_s;
      if (dl_out_valid_s) begin
        s1_z_q   <= z_in;
        s1_tag_q <= dl_tag_q[QPMM_LAT-1];
        s1_d1_q  <= {2'b00, z_in} - P1;
        s1_d2_q  <= {2'b00, z_in} - P2;
        s1_d3_q  <= {2'b00, z_in} - P3;
      end
    end
  end

  // Stage 2 select: largest non-negative trial difference wins.
  always_comb begin
    sel_s = s1_z_q;
    if (!s1_d3_q[W+1]) begin
      sel_s = s1_d3_q[W-1:0];
    end else if (!s1_d2_q[W+1]) begin
      sel_s = s1_d2_q[W-1:0];
    end else if (!s1_d1_q[W+1]) begin
      sel_s = s1_d1_q[W-1:0];
    end else begin
      sel_s = s1_z_q;
    end
  end

  // Stage 2 register feeding the FIFO write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= {W{1'b0}};
      s2_tag_q   <= {TAG_W{1'b0}};
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= sel_s;
      s2_tag_q   <= s1_tag_q;
    end
  end

  // FIFO occupancy next state.
  always_comb begin
    count_d = count_q;
    case ({s2_valid_q, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Output FIFO; credits guarantee a free slot whenever stage 2 writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= {W{1'b0}};
        fifo_tag_q[i]  <= {TAG_W{1'b0}};
      end
    end else begin
      if (s2_valid_q) begin
        fifo_data_q[wr_ptr_q] <= s2_data_q;
        fifo_tag_q[wr_ptr_q]  <= s2_tag_q;
        wr_ptr_q              <= wr_ptr_q + AW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      out_valid_q <= (count_d != {CW{1'b0}});
    end
  end

`ifdef QPMM_OUT_RANGE_CHK_EN
  localparam logic [W+1:0] P4 = P2 + P2;
  logic [W+1:0] d4_s;
  logic         range_err_q;
  logic         unused_d4_s;
  assign d4_s        = {2'b00, z_in} - P4;
  assign unused_d4_s = ^d4_s[W:0];
  assign range_err   = range_err_q;

  // Sticky flag for a Z that violates the Z < 4P contract.
  always_ff @(posedge clk) begin
    if (rst) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_q | (dl_out_valid_s & ~d4_s[W+1]);
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_qpmm_out_stage.sv
// Directed/scoreboard bench for qpmm_out_stage; models the multiplier as a latency-scheduled Z table.
module tb_qpmm_out_stage;
  localparam int W     = 256;
  localparam int TAG_W = 8;
  localparam int LAT   = 80;
  localparam int DEPTH = 4;
  localparam int SCH   = 16384;
  localparam logic [W-1:0] P = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  logic             clk = 1'b0;
  logic             rst;
  logic             iss_valid;
  logic [TAG_W-1:0] iss_tag;
  logic             iss_ok;
  logic [W-1:0]     z_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             ovf;
  logic             range_err;

  always #5 clk = ~clk;

  qpmm_out_stage #(.W(W), .P(P), .QPMM_LAT(LAT), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_tag(iss_tag), .iss_ok(iss_ok),
    .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .ovf(ovf), .range_err(range_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int credit_m;
  int first_ov;
  logic ovf_m;
  logic [W-1:0] z_sched [SCH];
  logic [W+TAG_W-1:0] sb [$];
  logic held_v;
  logic [W+TAG_W-1:0] held;
  logic [W+1:0] fourp;

  task automatic check_eq(input string name, input logic [W+TAG_W-1:0] got, input logic [W+TAG_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    z_in = z_sched[cyc % SCH];
  endtask

  // One bench cycle: drive inputs, check outputs of the current cycle, update the model.
  task automatic cycle(input logic v, input logic [TAG_W-1:0] tag, input logic [W-1:0] z,
                       input logic [W-1:0] e, input logic rdy);
    logic [W+TAG_W-1:0] head;
    logic [W+TAG_W-1:0] exp;
    iss_valid = v;
    iss_tag   = tag;
    out_ready = rdy;
    check_eq("iss_ok", iss_ok, credit_m != 0);
    head = {out_tag, out_data};
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (held_v && out_valid) check_eq("hold", head, held);
    held_v = out_valid && !rdy;
    held   = head;
    if (v) begin
      z_sched[(cyc + LAT) % SCH] = z;
      if (credit_m != 0) begin
        sb.push_back({tag, e});
        credit_m--;
      end else begin
        ovf_m = 1'b1;
      end
    end
    if (out_valid && rdy) begin
      check_eq("pop_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check_eq("pop_data", head, exp);
      end
      credit_m++;
    end
    tick();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, {W{1'b0}}, {W{1'b0}}, rdy);
  endtask

  task automatic drain();
    int budget;
    budget = LAT + 40;
    while (sb.size() != 0 && budget > 0) begin
      cycle(1'b0, 8'd0, {W{1'b0}}, {W{1'b0}}, 1'b1);
      budget--;
    end
    check_eq("drain_empty", sb.size(), 0);
    idle(4, 1'b1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    iss_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst      = 1'b0;
    sb.delete();
    credit_m = DEPTH;
    ovf_m    = 1'b0;
    held_v   = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_z();
    logic [W+1:0] r;
    r = {2'b00, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r = r % fourp;
    return r[W-1:0];
  endfunction

  initial begin
    logic [W-1:0] z;
    logic [W-1:0] zmod;
    logic [W-1:0] big;
    int c0;
    int issued;
    int budget;
    logic v;
    logic rerr_exp;
`ifdef QPMM_OUT_RANGE_CHK_EN
    rerr_exp = 1'b1;
`else
    rerr_exp = 1'b0;
`endif
    fourp = {2'b00, P} << 2;
    for (int i = 0; i < SCH; i++) z_sched[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    z_in = z_sched[0];
    iss_valid = 1'b0; iss_tag = 8'd0; out_ready = 1'b0; rst = 1'b1;
    held_v = 1'b0; first_ov = -1; credit_m = DEPTH; ovf_m = 1'b0;
    repeat (3) tick();
    do_reset();

    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, {W{1'b0}});
    check_eq("rst_out_tag", out_tag, 8'd0);
    check_eq("rst_iss_ok", iss_ok, 1'b1);
    check_eq("rst_ovf", ovf, 1'b0);
    check_eq("rst_range_err", range_err, 1'b0);

    // Directed canonicalization and latency
    first_ov = -1;
    c0 = cyc;
    big = P * 3 + 5;
    cycle(1'b1, 8'd1, {W{1'b0}}, {W{1'b0}}, 1'b1);
    cycle(1'b1, 8'd2, P, {W{1'b0}}, 1'b1);
    cycle(1'b1, 8'd3, big, 256'd5, 1'b1);
    cycle(1'b1, 8'd4, P - 1, P - 1, 1'b1);
    drain();
    check_eq("first_latency", first_ov - c0, LAT + 3);

    // Credit exhaustion and drop
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(11 + i), 256'(100 + i), 256'(100 + i), 1'b0);
    check_eq("iss_ok_full", iss_ok, 1'b0);
    cycle(1'b1, 8'd15, 256'd123, 256'd123, 1'b0);
    check_eq("ovf_set", ovf, 1'b1);
    idle(LAT + 4, 1'b0);
    check_eq("full_head_valid", out_valid, 1'b1);
    cycle(1'b0, 8'd0, {W{1'b0}}, {W{1'b0}}, 1'b1);
    check_eq("iss_ok_after_pop", iss_ok, 1'b1);
    drain();
    check_eq("ovf_sticky", ovf, 1'b1);
    do_reset();
    check_eq("ovf_cleared", ovf, 1'b0);

    // Reset with results buffered and in flight
    cycle(1'b1, 8'd21, 256'd21, 256'd21, 1'b0);
    cycle(1'b1, 8'd22, 256'd22, 256'd22, 1'b0);
    idle(LAT + 4, 1'b0);
    cycle(1'b1, 8'd23, 256'd23, 256'd23, 1'b0);
    cycle(1'b1, 8'd24, 256'd24, 256'd24, 1'b0);
    idle(10, 1'b0);
    do_reset();
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_iss_ok", iss_ok, 1'b1);
    idle(LAT + 10, 1'b1);
    cycle(1'b1, 8'd9, P + 3, 256'd3, 1'b1);
    drain();

    // Issue and pop in the same cycle at credit 1
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(31 + i), 256'(31 + i), 256'(31 + i), 1'b0);
    idle(LAT + 4, 1'b0);
    for (int i = 0; i < 20; i++) begin
      idle($urandom_range(45, 60), 1'b0);
      check_eq("credit1_before", iss_ok, 1'b1);
      z = rand_z();
      zmod = z % P;
      cycle(1'b1, 8'(40 + i), z, zmod, 1'b1);
      check_eq("credit1_after", iss_ok, 1'b1);
    end
    drain();
    check_eq("credit1_no_ovf", ovf, 1'b0);

    // Random traffic
    issued = 0;
    budget = 6000;
    while (issued < 200 && budget > 0) begin
      v = ($urandom_range(0, 2) != 0) && (credit_m != 0);
      z = rand_z();
      zmod = z % P;
      cycle(v, 8'(issued), z, zmod, $urandom_range(0, 3) != 0);
      if (v) issued++;
      budget--;
    end
    check_eq("random_issued", issued, 200);
    drain();
    check_eq("random_ovf", ovf, 1'b0);

    // Range check on an out-of-contract Z, then a normal one
    big = P * 4 + 1;
    cycle(1'b1, 8'd71, big, P + 1, 1'b1);
    idle(LAT + 3, 1'b1);
    check_eq("range_err_set", range_err, rerr_exp);
    big = P * 2 + 7;
    cycle(1'b1, 8'd72, big, 256'd7, 1'b1);
    drain();
    check_eq("range_err_held", range_err, rerr_exp);
    check_eq("final_ovf", ovf, ovf_m);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
